spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- Transmit-side SPI master: accepts a parallel word over a valid/ready handshake and shifts it out MSB-first on SCLK/MOSI with CS framing.
- Mode 0 timing: SCLK idles low, MOSI changes on the falling edge, the receiver samples on the rising edge.
- Full-duplex: MISO is captured on the same edges and returned as a parallel word.
- Drives the existing SPI slave receiver for board-to-board links and loopback testing; runs on the 32 MHz system clock.

Parameters:
- DATA_WIDTH, 32, bits per frame; must be >= 2.
- CLK_DIV, 2, clk cycles per SCLK half-period; must be >= 1. Default gives 8 MHz SCLK from 32 MHz clk.
- CS_GAP, 4, minimum clk cycles CS stays high between frames; must be >= 1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- dataIn  input  DATA_WIDTH  word to transmit; sampled only on the accept cycle.
- dataValid  input  1  dataIn valid.
- dataReady  output  1  block can accept a word this cycle.
- rxData  output  DATA_WIDTH  last word captured from MISO; holds until the next frame completes.
- done  output  1  one-cycle pulse when a frame completes and rxData updates.
- busy  output  1  high from the accept cycle until the GAP state exits.
- sclk  output  1  SPI clock.
- mosi  output  1  SPI data out.
- miso  input  1  SPI data in; the slave drives it synchronously to sclk.
- cs  output  1  chip select, active low.

Behaviour:
- All outputs are registered.
- While reset=0 (asynchronous): cs=1, sclk=0, mosi=0, dataReady=0, busy=0, done=0, rxData=0; state=IDLE; counters cleared.
- Reset asserted mid-frame: the frame is aborted immediately, cs rises asynchronously and no done pulse is produced.
- States: IDLE, SETUP, HIGH, LOW, HOLD, GAP.
- IDLE:
  - dataReady=1.
  - Accept when dataValid&&dataReady: latch dataIn into the tx shift register and go to SETUP.
  - dataValid while dataReady=0 is ignored; no queuing.
- SETUP:
  - First cycle shows cs=0, mosi=dataIn[DATA_WIDTH-1], sclk=0, busy=1, dataReady=0.
  - Lasts CLK_DIV cycles, then go to HIGH.
- HIGH:
  - sclk=1 for CLK_DIV cycles.
  - miso is sampled into the rx shift register (LSB end) in the first HIGH cycle.
  - Then go to LOW.
- LOW:
  - sclk=0 for CLK_DIV cycles; bitCount increments on entry.
  - If bitCount < DATA_WIDTH: mosi shifts to the next bit on the entry cycle, then return to HIGH.
  - If bitCount == DATA_WIDTH: go to HOLD; mosi holds its last value.
- HOLD:
  - cs=0, sclk=0 for CLK_DIV cycles.
  - Then cs=1, rxData<=rx shift register, done=1 for exactly one cycle, go to GAP.
- GAP: cs=1 for CS_GAP cycles, then IDLE. busy drops on the cycle dataReady rises.
- Frame timing:
  - CS low for CLK_DIV*(2*DATA_WIDTH+2) cycles: 132 at defaults.
  - Accept to next possible accept: that figure + CS_GAP + 1 cycles.
- Exactly DATA_WIDTH rising SCLK edges per frame; no SCLK edges while cs=1.
- Counters:
  - bitCount is $clog2(DATA_WIDTH)+1 bits wide and saturates at DATA_WIDTH.
  - The divider counter wraps at CLK_DIV-1.
- Back-to-back: dataValid held high is accepted on the first IDLE cycle after GAP.

Decomposition:
- spi_pkg holds the state enum type (spi_state_t) and the default DATA_WIDTH/CLK_DIV constants.
- One sub-module: spi_sclk_div.
  - Half-period tick generator with enable, clear and a CLK_DIV parameter.
  - Emits a one-cycle tick every CLK_DIV cycles.
  - spi_master's FSM advances phases on that tick.

Test Plan:
- Reset, then idle 8 cycles -> cs=1, sclk=0, mosi=0, dataReady=1, busy=0, zero SCLK edges counted.
- Send 32'hA5A5_5A5A with miso tied 1 -> exactly 32 rising edges; bits sampled at rising sclk equal A5A55A5A MSB-first; cs low 132 cycles; done one cycle; rxData=32'hFFFF_FFFF.
- Loopback mosi->miso, 4 random words back-to-back with dataValid held high -> each rxData equals the word sent; cs high >= 4 cycles between frames; dataReady=0 throughout each frame.
- Instantiate the existing SPI slave receiver on sclk/mosi/cs and send 32'hDEAD_BEEF -> the slave's serialOut/serialEn stream reassembles to DEADBEEF.
- Pulse dataValid during a frame with a different word -> ignored; the transmitted frame and the next accepted word are unchanged.
- Assert reset at the 10th rising sclk -> cs=1 and sclk=0 within the same cycle (asynchronous); no done pulse; after release, the next frame 32'h0000_0001 transmits correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and default sizing for the SPI master.
//   spi_state_t      - frame sequencer states
//   DefaultDataWidth - bits per frame
//   DefaultClkDiv    - clk cycles per SCLK half-period
//   DefaultCsGap     - minimum clk cycles CS stays high between frames
package spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow,
        StHold,
        StGap
    } spi_state_t;

    localparam int unsigned DefaultDataWidth = 32;
    localparam int unsigned DefaultClkDiv    = 2;
    localparam int unsigned DefaultCsGap     = 4;

endpackage

// File: rtl/spi_sclk_div.sv
// spi_sclk_div: half-period tick generator for the SPI master.
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset
//   en_i    - count while high
//   clr_i   - force the counter back to zero (wins over en_i)
//   first_o - counter is at zero, i.e. first cycle of a half-period
//   tick_o  - one-cycle pulse on the last cycle of each CLK_DIV-cycle half-period
module spi_sclk_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic first_o,
    output logic tick_o
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o  = en_i && (cnt_q == CntLast);
    assign first_o = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// spi_master: transmit-side SPI mode-0 master with full-duplex MISO capture.
//   clk       - system clock
//   reset     - asynchronous active-low reset
//   dataIn    - word to transmit, sampled on the accept cycle only
//   dataValid - dataIn valid
//   dataReady - block can accept a word this cycle
//   rxData    - last word captured from MISO, held until the next frame completes
//   done      - one-cycle pulse when a frame completes and rxData updates
//   busy      - high from accept until the inter-frame gap ends
//   sclk      - SPI clock, idles low
//   mosi      - SPI data out, MSB first, changes while sclk is low
//   miso      - SPI data in, captured while sclk is high
//   cs        - chip select, active low
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefaultDataWidth,
    parameter int unsigned CLK_DIV    = DefaultClkDiv,
    parameter int unsigned CS_GAP     = DefaultCsGap
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  dataValid,
    output logic                  dataReady,
    output logic [DATA_WIDTH-1:0] rxData,
    output logic                  done,
    output logic                  busy,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs
);

    localparam int unsigned BitW = $clog2(DATA_WIDTH) + 1;
    localparam int unsigned GapW = $clog2(CS_GAP + 1);
    localparam logic [BitW-1:0] BitMax  = BitW'(DATA_WIDTH);
    localparam logic [GapW-1:0] GapLast = GapW'(CS_GAP - 1);

    spi_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] rxdata_q, rxdata_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
    logic                  cs_q, cs_d;
    logic                  sclk_q, sclk_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  div_en, div_clr, div_first, div_tick;
    logic [BitW-1:0]       bit_inc;

    spi_sclk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_div (
        .clk_i  (clk),
        .rst_ni (reset),
        .en_i   (div_en),
        .clr_i  (div_clr),
        .first_o(div_first),
        .tick_o (div_tick)
    );

    // Saturating bit counter increment.
    assign bit_inc = (bit_cnt_q == BitMax) ? bit_cnt_q : bit_cnt_q + BitW'(1);

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rxdata_d  = rxdata_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        cs_d      = cs_q;
        sclk_d    = sclk_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        div_en    = 1'b0;
        div_clr   = 1'b1;

        unique case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (dataValid && ready_q) begin
                    tx_d      = dataIn;
                    rx_d      = '0;
                    bit_cnt_d = '0;
                    cs_d      = 1'b0;
                    sclk_d    = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                div_en  = 1'b1;
                div_clr = 1'b0;
                if (div_tick) begin
                    sclk_d  = 1'b1;
                    state_d = StHigh;
                end
            end
            StHigh: begin
                div_en  = 1'b1;
                div_clr = 1'b0;
                if (div_first) begin
                    rx_d = {rx_q[DATA_WIDTH-2:0], miso};
                end
                if (div_tick) begin
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_inc;
                    // Falling edge: present the next bit unless the word is exhausted.
                    if (bit_inc < BitMax) begin
                        tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
                    end
                    state_d = StLow;
                end
            end
            StLow: begin
                div_en  = 1'b1;
                div_clr = 1'b0;
                if (div_tick) begin
                    if (bit_cnt_q == BitMax) begin
                        state_d = StHold;
                    end else begin
                        sclk_d  = 1'b1;
                        state_d = StHigh;
                    end
                end
            end
            StHold: begin
                div_en  = 1'b1;
                div_clr = 1'b0;
                if (div_tick) begin
                    cs_d      = 1'b1;
                    rxdata_d  = rx_q;
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = StGap;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            tx_q      <= '0;
            rx_q      <= '0;
            rxdata_q  <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rxdata_q  <= rxdata_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // mosi is the top of the tx shift register, so it is registered and holds after the last bit.
    assign mosi      = tx_q[DATA_WIDTH-1];
    assign cs        = cs_q;
    assign sclk      = sclk_q;
    assign dataReady = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rxData    = rxdata_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master with a frame-level reference model.
module tb_spi_master;

    localparam int unsigned DW        = 32;
    localparam int unsigned DIV       = 2;
    localparam int unsigned GAP       = 4;
    localparam int unsigned FRAME_LOW = DIV * (2 * DW + 2);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] dataIn = '0;
    logic          dataValid = 1'b0;
    logic          dataReady;
    logic [DW-1:0] rxData;
    logic          done;
    logic          busy;
    logic          sclk;
    logic          mosi;
    logic          miso;
    logic          cs;
    logic          loopback = 1'b0;

    always #5 clk = ~clk;

    assign miso = loopback ? mosi : 1'b1;

    spi_master #(
        .DATA_WIDTH(DW),
        .CLK_DIV   (DIV),
        .CS_GAP    (GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .dataIn   (dataIn),
        .dataValid(dataValid),
        .dataReady(dataReady),
        .rxData   (rxData),
        .done     (done),
        .busy     (busy),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .cs       (cs)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in serial receiver: one serialOut bit per rising sclk while selected.
    logic          slv_clr = 1'b0;
    logic [31:0]   slv_word;
    int            slv_bits;
    always @(posedge sclk or posedge slv_clr) begin
        if (slv_clr) begin
            slv_word <= '0;
            slv_bits <= 0;
        end else if (!cs) begin
            slv_word <= {slv_word[30:0], mosi};
            slv_bits <= slv_bits + 1;
        end
    end

    // Frame-level reference model: expected words per accepted transfer.
    logic [31:0] exp_tx_q[$];
    logic [31:0] exp_rx_q[$];

    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        in_frame = 1'b0;
    logic        seen_gap = 1'b0;
    int          low_cnt = 0, gap_cnt = 0, edge_cnt = 0;
    int          frames_done = 0, done_total = 0, last_edges = 0, last_low = 0;
    logic [31:0] got = '0, cur_tx = '0, cur_rx = '0, model_rx = '0, last_got = '0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_cs   = 1'b1;
            prev_sclk = 1'b0;
            in_frame  = 1'b0;
            seen_gap  = 1'b0;
            model_rx  = '0;
        end else begin
            if (done) done_total++;
            check("done_pulse", done, (!prev_cs && cs && in_frame));
            if (cs) begin
                check("sclk_idle_when_deselected", sclk, 1'b0);
            end else begin
                check("ready_low_in_frame", dataReady, 1'b0);
                check("busy_high_in_frame", busy, 1'b1);
            end
            if (prev_cs && !cs) begin
                in_frame = 1'b1;
                low_cnt  = 1;
                edge_cnt = 0;
                got      = '0;
                if (seen_gap) check("cs_gap_min", (gap_cnt >= GAP), 1'b1);
                if (exp_tx_q.size() == 0) begin
                    check("unexpected_frame", exp_tx_q.size(), 1);
                    cur_tx = '0;
                    cur_rx = '0;
                end else begin
                    cur_tx = exp_tx_q.pop_front();
                    cur_rx = exp_rx_q.pop_front();
                end
            end else if (!cs) begin
                low_cnt++;
            end
            if (!cs && sclk && !prev_sclk) begin
                edge_cnt++;
                got = {got[30:0], mosi};
            end
            if (!prev_cs && cs && in_frame) begin
                check("frame_edges", edge_cnt, DW);
                check("frame_cs_low", low_cnt, FRAME_LOW);
                check("frame_tx_bits", got, cur_tx);
                check("frame_rx_word", rxData, cur_rx);
                model_rx   = cur_rx;
                last_got   = got;
                last_edges = edge_cnt;
                last_low   = low_cnt;
                frames_done++;
                in_frame = 1'b0;
                seen_gap = 1'b1;
                gap_cnt  = 1;
            end else if (cs) begin
                gap_cnt++;
            end
            check("rx_hold", rxData, model_rx);
            prev_cs   = cs;
            prev_sclk = sclk;
        end
    end

    int accept_cyc = 0;

    task automatic send(input logic [31:0] w, input bit hold);
        int t = 0;
        dataIn    = w;
        dataValid = 1'b1;
        while (!dataReady && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check("accept_wait", dataReady, 1'b1);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        exp_tx_q.push_back(w);
        exp_rx_q.push_back(loopback ? w : 32'hFFFF_FFFF);
        if (!hold) dataValid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while (frames_done < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (frames_done < n) check("frame_wait", frames_done, n);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int          fb, dn, n, t, prev_acc;
        logic        ps;
        logic [31:0] words[4];

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        check("rst_cs", cs, 1'b1);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_ready", dataReady, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rxdata", rxData, 32'h0);
        reset = 1'b1;

        // Idle for 8 cycles.
        n  = 0;
        ps = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sclk && !ps) n++;
            ps = sclk;
            check("idle_cs", cs, 1'b1);
            check("idle_mosi", mosi, 1'b0);
            check("idle_ready", dataReady, 1'b1);
            check("idle_busy", busy, 1'b0);
        end
        check("idle_sclk_edges", n, 0);

        // Single frame, miso tied high.
        loopback = 1'b0;
        fb = frames_done;
        dn = done_total;
        send(32'hA5A5_5A5A, 1'b0);
        wait_frames(fb + 1);
        check("a5_tx_literal", last_got, 32'hA5A5_5A5A);
        check("a5_edges_literal", last_edges, 32);
        check("a5_cs_low_literal", last_low, 132);
        check("a5_rx_literal", rxData, 32'hFFFF_FFFF);
        check("a5_one_done", done_total - dn, 1);

        // Loopback, back-to-back with dataValid held high.
        loopback = 1'b1;
        fb = frames_done;
        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            words[i] = $urandom;
            send(words[i], 1'b1);
            if (i > 0) check("b2b_accept_interval", accept_cyc - prev_acc, 137);
            prev_acc = accept_cyc;
        end
        dataValid = 1'b0;
        wait_frames(fb + 4);
        check("b2b_last_rx", rxData, words[3]);

        // Serial receiver reassembly.
        slv_clr = 1'b1;
        #1;
        slv_clr = 1'b0;
        fb = frames_done;
        send(32'hDEAD_BEEF, 1'b0);
        wait_frames(fb + 1);
        check("slave_word", slv_word, 32'hDEAD_BEEF);
        check("slave_bits", slv_bits, 32);

        // dataValid pulsed mid-frame is ignored.
        fb = frames_done;
        send(32'h3C3C_C3C3, 1'b0);
        repeat (20) @(negedge clk);
        dataIn    = 32'h1234_5678;
        dataValid = 1'b1;
        repeat (3) @(negedge clk);
        dataValid = 1'b0;
        dataIn    = '0;
        wait_frames(fb + 1);
        check("ignored_tx_literal", last_got, 32'h3C3C_C3C3);
        send(32'h0F1E_2D3C, 1'b0);
        wait_frames(fb + 2);
        check("after_ignore_tx", last_got, 32'h0F1E_2D3C);
        repeat (200) @(negedge clk);
        check("no_queued_frame", frames_done, fb + 2);

        // Asynchronous reset at the 10th rising sclk.
        fb = frames_done;
        dn = done_total;
        send(32'hCAFE_F00D, 1'b0);
        n  = 0;
        t  = 0;
        ps = 1'b0;
        while (n < 10 && t < 1000) begin
            @(posedge clk);
            #1;
            if (sclk && !ps) n++;
            ps = sclk;
            t++;
        end
        check("tenth_edge_seen", n, 10);
        #2 reset = 1'b0;
        #1;
        check("abort_cs", cs, 1'b1);
        check("abort_sclk", sclk, 1'b0);
        check("abort_ready", dataReady, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_rxdata", rxData, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        exp_tx_q.delete();
        exp_rx_q.delete();
        repeat (5) @(negedge clk);
        check("abort_no_done", done_total, dn);
        check("abort_no_frame", frames_done, fb);
        send(32'h0000_0001, 1'b0);
        wait_frames(fb + 1);
        check("post_reset_tx", last_got, 32'h0000_0001);
        check("post_reset_rx", rxData, 32'h0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
